// File: rtl/network_rx_frame_filter_pkg.sv
// Shared types and constants for the RX frame filter: bus payload, frame class, FSM states.
package network_rx_frame_filter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAC_W   = 48;
  localparam int unsigned PERF_W  = 32;
  localparam int unsigned WCNT_W  = 3;

  localparam logic [WCNT_W-1:0] WORD_SAT = WCNT_W'(4);

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;

  // Muxed Ethernet RX bus word; first byte on the wire is data[31:24].
  typedef struct packed {
    logic              start;
    logic              data_valid;
    logic [2:0]        bytes_valid;
    logic [DATA_W-1:0] data;
    logic              commit;
    logic              drop;
  } eth_rx_bus_t;

  typedef enum logic [1:0] {
    ETH_CLASS_OTHER = 2'd0,
    ETH_CLASS_IPV4  = 2'd1,
    ETH_CLASS_ARP   = 2'd2,
    ETH_CLASS_IPV6  = 2'd3
  } eth_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_BODY    = 2'd2,
    ST_DISCARD = 2'd3
  } filt_state_e;

  // Map an EtherType onto a frame class; anything unknown (VLAN included) is OTHER.
  function automatic eth_class_e classify(input logic [15:0] etype);
    case (etype)
      ETYPE_IPV4: return ETH_CLASS_IPV4;
      ETYPE_ARP:  return ETH_CLASS_ARP;
      ETYPE_IPV6: return ETH_CLASS_IPV6;
      default:    return ETH_CLASS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/network_rx_frame_filter_eth_rx_header_parser.sv
// Header parser: counts words since start, checks the destination MAC and extracts the EtherType class.
module network_rx_frame_filter_eth_rx_header_parser
  import network_rx_frame_filter_pkg::*;
#(
  parameter bit ALLOW_MULTICAST = 1'b1,
  parameter bit PROMISCUOUS     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_valid,
  input  logic [2:0]        bytes_valid,
  input  logic [DATA_W-1:0] data,
  input  logic [MAC_W-1:0]  our_mac,
  output logic              addr_ok,
  output logic [1:0]        frame_class_c,
  output logic              header_done_c
);

  logic [WCNT_W-1:0] word_cnt;
  logic [WCNT_W-1:0] word_idx_c;
  logic [MAC_W-1:0]  mac_q;
  logic [31:0]       mac_hi_c;
  logic              hi_match;
  logic              hi_bcast;
  logic              group_bit;

  // A start word is always word 0, and compares against the MAC as sampled on that cycle.
  assign word_idx_c    = start ? '0 : word_cnt;
  assign mac_hi_c      = start ? our_mac[47:16] : mac_q[47:16];
  assign header_done_c = data_valid && (word_idx_c == WCNT_W'(3)) && (bytes_valid >= 3'd2);
  assign frame_class_c = 2'(classify(data[31:16]));

  // Word counter, MAC latch and the two-word destination address compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      mac_q     <= '0;
      hi_match  <= 1'b0;
      hi_bcast  <= 1'b0;
      group_bit <= 1'b0;
      addr_ok   <= 1'b0;
    end else begin
      if (start) begin
        mac_q    <= our_mac;
        addr_ok  <= 1'b0;
        word_cnt <= data_valid ? WCNT_W'(1) : '0;
      end else if (data_valid && (word_cnt != WORD_SAT)) begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end

      if (data_valid && (word_idx_c == '0)) begin
        hi_match  <= (data == mac_hi_c);
        hi_bcast  <= (data == 32'hFFFF_FFFF);
        group_bit <= data[24];
      end

      if (data_valid && (word_idx_c == WCNT_W'(1))) begin
        addr_ok <= PROMISCUOUS
                || (hi_match && (data[31:16] == mac_q[15:0]))
                || (hi_bcast && (data[31:16] == 16'hFFFF))
                || (ALLOW_MULTICAST && group_bit);
      end
    end
  end

endmodule

// File: rtl/network_rx_frame_filter.sv
// RX frame filter: forwards the muxed RX bus with one cycle of latency, turning commit into drop
// for rejected, runt or link-aborted frames, and keeps accept/reject counters.
module network_rx_frame_filter
  import network_rx_frame_filter_pkg::*;
#(
  parameter bit ALLOW_MULTICAST = 1'b1,
  parameter bit PROMISCUOUS     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MAC_W-1:0]  our_mac,
  input  logic              link_up,
  input  eth_rx_bus_t       rx_bus_in,
  output eth_rx_bus_t       rx_bus_out,
  output logic [1:0]        rx_class,
  output logic              rx_class_valid,
  output logic [PERF_W-1:0] perf_frames_accepted,
  output logic [PERF_W-1:0] perf_frames_rejected
);

  filt_state_e state, state_d;
  eth_rx_bus_t bus_d;
  logic [1:0]  class_d;
  logic        class_valid_d;
  logic        drop_pend, drop_pend_d;
  logic        inc_acc_c;
  logic        rej_old_c;
  logic        rej_cur_c;
  logic        end_drop_c;
  logic        end_commit_c;
  logic        addr_ok;
  logic [1:0]  frame_class_c;
  logic        header_done_c;

  network_rx_frame_filter_eth_rx_header_parser #(
    .ALLOW_MULTICAST (ALLOW_MULTICAST),
    .PROMISCUOUS     (PROMISCUOUS)
  ) u_parser (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (rx_bus_in.start),
    .data_valid    (rx_bus_in.data_valid),
    .bytes_valid   (rx_bus_in.bytes_valid),
    .data          (rx_bus_in.data),
    .our_mac       (our_mac),
    .addr_ok       (addr_ok),
    .frame_class_c (frame_class_c),
    .header_done_c (header_done_c)
  );

  // Commit together with drop counts as drop.
  assign end_drop_c   = rx_bus_in.drop;
  assign end_commit_c = rx_bus_in.commit && !rx_bus_in.drop;

  // Next state, next output word, class tracking and counter increments.
  always_comb begin
    state_d       = state;
    bus_d         = rx_bus_in;
    class_d       = rx_class;
    class_valid_d = rx_class_valid;
    drop_pend_d   = 1'b0;
    inc_acc_c     = 1'b0;
    rej_old_c     = 1'b0;
    rej_cur_c     = 1'b0;

    if (rx_bus_out.commit || rx_bus_out.drop) begin
      class_valid_d = 1'b0;
    end

    if (rx_bus_in.start) begin
      // A new start closes whatever was open; a frame still owed a drop is counted here instead.
      class_valid_d = 1'b0;
      if ((state == ST_HEADER) || (state == ST_BODY) || ((state == ST_DISCARD) && drop_pend)) begin
        rej_old_c = 1'b1;
      end
      if (!link_up) begin
        state_d      = ST_DISCARD;
        drop_pend_d  = 1'b1;
        bus_d.commit = 1'b0;
        bus_d.drop   = 1'b0;
      end else if (end_commit_c || end_drop_c) begin
        bus_d.commit = 1'b0;
        bus_d.drop   = 1'b1;
        rej_cur_c    = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        state_d = ST_HEADER;
      end
    end else begin
      case (state)
        ST_HEADER, ST_BODY: begin
          if (!link_up) begin
            bus_d.data_valid = 1'b0;
            bus_d.commit     = 1'b0;
            bus_d.drop       = 1'b1;
            rej_cur_c        = 1'b1;
            state_d          = ST_DISCARD;
          end else begin
            if ((state == ST_HEADER) && header_done_c) begin
              class_d       = frame_class_c;
              class_valid_d = 1'b1;
              state_d       = ST_BODY;
            end
            if (end_drop_c) begin
              bus_d.commit = 1'b0;
              rej_cur_c    = 1'b1;
              state_d      = ST_IDLE;
            end else if (end_commit_c) begin
              if (((state == ST_BODY) || header_done_c) && addr_ok) begin
                inc_acc_c = 1'b1;
              end else begin
                bus_d.commit = 1'b0;
                bus_d.drop   = 1'b1;
                rej_cur_c    = 1'b1;
              end
              state_d = ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          bus_d.data_valid = 1'b0;
          bus_d.commit     = 1'b0;
          bus_d.drop       = drop_pend;
          rej_cur_c        = drop_pend;
        end
        default: ;
      endcase
    end
  end

  // State, output bus and class registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      drop_pend      <= 1'b0;
      rx_bus_out     <= '0;
      rx_class       <= 2'(ETH_CLASS_OTHER);
      rx_class_valid <= 1'b0;
    end else begin
      state          <= state_d;
      drop_pend      <= drop_pend_d;
      rx_bus_out     <= bus_d;
      rx_class       <= class_d;
      rx_class_valid <= class_valid_d;
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_frames_accepted <= '0;
      perf_frames_rejected <= '0;
    end else begin
      perf_frames_accepted <= perf_frames_accepted + PERF_W'(inc_acc_c);
      perf_frames_rejected <= perf_frames_rejected + PERF_W'(rej_old_c) + PERF_W'(rej_cur_c);
    end
  end

endmodule
